// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared states, line levels and width helper for the frame transmitter
// The PARITY state is only entered when PARITY_EN is defined.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic int ones_cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_frame_transmitter_bit_timer.sv
// rtl/serial_frame_transmitter_bit_timer.sv - counts clk cycles within one serial bit
// bit_end is high in the last cycle of a bit while enabled; independent of PARITY_EN.
module bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_frame_transmitter.sv
// rtl/serial_frame_transmitter.sv - start/payload/stop serialiser with collect window and ones count
// Defining PARITY_EN inserts an even parity bit between payload and stop.
module serial_frame_transmitter
  import serial_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                serout,
  output logic                                collect_out,
  output logic [ones_cnt_width(DATA_W)-1:0]   ones_cnt,
  output logic                                done
);

  localparam int OW = ones_cnt_width(DATA_W);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shifted;
  logic [IW-1:0]     idx_q, idx_d;
  logic [OW-1:0]     acc_q, acc_d, acc_next;
  logic [OW-1:0]     ones_q, ones_d;
  logic              serout_q, serout_d;
  logic              collect_q, collect_d;
  logic              accept, timer_clear, timer_en, bit_end;

  assign in_ready    = (state_q == IDLE);
  assign accept      = in_valid && in_ready;
  assign timer_en    = (state_q != IDLE);
  assign shifted     = shreg_q >> 1;
  assign acc_next    = acc_q + OW'(shreg_q[0]);
  assign serout      = serout_q;
  assign collect_out = collect_q;
  assign ones_cnt    = ones_q;

  bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .bit_end(bit_end)
  );

  // serout/collect are registered: each branch loads the level of the bit that starts next
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    ones_d      = ones_q;
    serout_d    = serout_q;
    collect_d   = collect_q;
    timer_clear = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = START;
          serout_d    = START_LEVEL;
          shreg_d     = in_data;
          idx_d       = '0;
          acc_d       = '0;
          timer_clear = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          serout_d  = shreg_q[0];
          collect_d = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shifted;
          acc_d   = acc_next;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            collect_d = 1'b0;
`ifdef PARITY_EN
            state_d  = PARITY;
            serout_d = acc_next[0];
`else
            state_d  = STOP;
            serout_d = IDLE_LEVEL;
`endif
          end else begin
            serout_d = shifted[0];
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serout_d = IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          state_d = IDLE;
          ones_d  = acc_q;
        end
      end
      default: begin
        state_d   = IDLE;
        serout_d  = IDLE_LEVEL;
        collect_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      ones_q    <= '0;
      serout_q  <= IDLE_LEVEL;
      collect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      ones_q    <= ones_d;
      serout_q  <= serout_d;
      collect_q <= collect_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// tb/tb_serial_frame_transmitter.sv - directed bench for the frame transmitter (BIT_CYCLES 1 and 3)
// Define PARITY_EN for both RTL and bench to exercise the parity frame.
module tb_serial_frame_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       va, vb;
  logic [7:0] da, db;
  logic       ready_a, ser_a, col_a, done_a;
  logic       ready_b, ser_b, col_b, done_b;
  logic [3:0] ones_a, ones_b;

  int total = 0;
  int bad   = 0;

`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic frame_bits [0:NB-1];

  serial_frame_transmitter #(.DATA_W(8), .BIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(ready_a), .in_data(da),
    .serout(ser_a), .collect_out(col_a), .ones_cnt(ones_a), .done(done_a)
  );

  serial_frame_transmitter #(.DATA_W(8), .BIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(ready_b), .in_data(db),
    .serout(ser_b), .collect_out(col_b), .ones_cnt(ones_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [7:0] w);
    frame_bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) frame_bits[k+1] = w[k];
`ifdef PARITY_EN
    frame_bits[9] = ^w;
`endif
    frame_bits[NB-1] = 1'b1;
  endtask

  task automatic run_frame_a(input logic [7:0] w, input logic [3:0] prev, input logic [3:0] exp_ones);
    int   rx;
    logic exp_col, exp_done;
    build_frame(w);
    va = 1'b1;
    da = w;
    tick();
    va = 1'b0;
    total++;
    if (ready_a !== 1'b0) begin bad++; $display("FAIL ready_busy_%02h: got %b want 0", w, ready_a); end
    rx = 0;
    for (int i = 0; i < NB; i++) begin
      exp_col  = (i >= 1 && i <= 8);
      exp_done = (i == NB - 1);
      total++;
      if (ser_a !== frame_bits[i]) begin bad++; $display("FAIL serout_%02h bit%0d: got %b want %b", w, i, ser_a, frame_bits[i]); end
      total++;
      if (col_a !== exp_col) begin bad++; $display("FAIL collect_%02h bit%0d: got %b want %b", w, i, col_a, exp_col); end
      total++;
      if (done_a !== exp_done) begin bad++; $display("FAIL done_%02h bit%0d: got %b want %b", w, i, done_a, exp_done); end
      if (i == 4) begin
        total++;
        if (ones_a !== prev) begin bad++; $display("FAIL ones_hold_%02h: got %0d want %0d", w, ones_a, prev); end
      end
      if (col_a === 1'b1 && ser_a === 1'b1) rx++;
      tick();
    end
    total++;
    if (ones_a !== exp_ones) begin bad++; $display("FAIL ones_cnt_%02h: got %0d want %0d", w, ones_a, exp_ones); end
    total++;
    if (rx != int'(exp_ones)) begin bad++; $display("FAIL rx_count_%02h: got %0d want %0d", w, rx, exp_ones); end
    total++;
    if (ready_a !== 1'b1 || ser_a !== 1'b1 || done_a !== 1'b0) begin
      bad++; $display("FAIL idle_after_%02h: got ready=%b ser=%b done=%b want 1 1 0", w, ready_a, ser_a, done_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    va = 1'b0; vb = 1'b0; da = 8'h00; db = 8'h00;
    #12;
    total++;
    if (ser_a !== 1'b1 || col_a !== 1'b0 || ready_a !== 1'b1 || ones_a !== 4'd0 || done_a !== 1'b0) begin
      bad++; $display("FAIL reset_a: got ser=%b col=%b rdy=%b ones=%0d done=%b want 1 0 1 0 0", ser_a, col_a, ready_a, ones_a, done_a);
    end
    total++;
    if (ser_b !== 1'b1 || col_b !== 1'b0 || ready_b !== 1'b1 || ones_b !== 4'd0 || done_b !== 1'b0) begin
      bad++; $display("FAIL reset_b: got ser=%b col=%b rdy=%b ones=%0d done=%b want 1 0 1 0 0", ser_b, col_b, ready_b, ones_b, done_b);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ser_a !== 1'b1 || col_a !== 1'b0 || ready_a !== 1'b1 || ones_a !== 4'd0) begin
        bad++; $display("FAIL idle_after_reset cyc%0d: got ser=%b col=%b rdy=%b ones=%0d want 1 0 1 0", i, ser_a, col_a, ready_a, ones_a);
      end
    end
  endtask

  task automatic test_b5();
    run_frame_a(8'hB5, 4'd0, 4'd5);
  endtask

  task automatic test_bit_cycles();
    logic exp_col, exp_done;
    build_frame(8'h01);
    vb = 1'b1;
    db = 8'h01;
    tick();
    for (int c = 0; c < 3 * NB; c++) begin
      exp_col  = (c / 3 >= 1 && c / 3 <= 8);
      exp_done = (c == 3 * NB - 1);
      total++;
      if (ser_b !== frame_bits[c/3]) begin bad++; $display("FAIL slow_serout cyc%0d: got %b want %b", c, ser_b, frame_bits[c/3]); end
      total++;
      if (col_b !== exp_col) begin bad++; $display("FAIL slow_collect cyc%0d: got %b want %b", c, col_b, exp_col); end
      total++;
      if (done_b !== exp_done) begin bad++; $display("FAIL slow_done cyc%0d: got %b want %b", c, done_b, exp_done); end
      total++;
      if (ready_b !== 1'b0) begin bad++; $display("FAIL slow_ready_busy cyc%0d: got %b want 0", c, ready_b); end
      tick();
    end
    total++;
    if (ready_b !== 1'b1 || ones_b !== 4'd1 || ser_b !== 1'b1) begin
      bad++; $display("FAIL slow_gap: got rdy=%b ones=%0d ser=%b want 1 1 1", ready_b, ones_b, ser_b);
    end
    tick();
    vb = 1'b0;
    total++;
    if (ready_b !== 1'b0 || ser_b !== 1'b0) begin
      bad++; $display("FAIL slow_reaccept: got rdy=%b ser=%b want 0 0", ready_b, ser_b);
    end
    for (int c = 0; c < 3 * NB; c++) tick();
    total++;
    if (ready_b !== 1'b1 || ones_b !== 4'd1) begin
      bad++; $display("FAIL slow_second_end: got rdy=%b ones=%0d want 1 1", ready_b, ones_b);
    end
  endtask

  task automatic test_zero_ones();
    run_frame_a(8'h00, 4'd5, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ser_a !== 1'b1 || ones_a !== 4'd0) begin
        bad++; $display("FAIL between_frames cyc%0d: got ser=%b ones=%0d want 1 0", i, ser_a, ones_a);
      end
    end
    run_frame_a(8'hFF, 4'd0, 4'd8);
  endtask

  task automatic test_reset_mid_frame();
    va = 1'b1;
    da = 8'hAA;
    tick();
    va = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (ser_a !== 1'b0 || col_a !== 1'b1) begin
      bad++; $display("FAIL pre_abort: got ser=%b col=%b want 0 1", ser_a, col_a);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ser_a !== 1'b1 || col_a !== 1'b0 || ready_a !== 1'b1 || ones_a !== 4'd0 || done_a !== 1'b0) begin
      bad++; $display("FAIL abort_outputs: got ser=%b col=%b rdy=%b ones=%0d done=%b want 1 0 1 0 0", ser_a, col_a, ready_a, ones_a, done_a);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (done_a !== 1'b0 || ser_a !== 1'b1) begin bad++; $display("FAIL abort_hold cyc%0d: got done=%b ser=%b want 0 1", i, done_a, ser_a); end
    end
    rst = 1'b1;
    tick();
    run_frame_a(8'hAA, 4'd0, 4'd4);
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    run_frame_a(8'h07, 4'd4, 4'd3);
  endtask
`endif

  initial begin
    test_reset();
    test_b5();
    test_bit_cycles();
    test_zero_ones();
    test_reset_mid_frame();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
